// File: rtl/pipe_skid_stage_pkg.sv
// Shared types and default widths for the elastic inter-stage pipeline register.
// The exception struct is the single source of the exception vector width.
package pipe_skid_stage_pkg;

  typedef struct packed {
    logic instr_misalign;
    logic instr_fault;
    logic illegal_instr;
    logic breakpoint;
    logic load_misalign;
    logic load_fault;
    logic store_misalign;
    logic store_fault;
    logic ecall;
  } pipe_exc_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_EXC_W  = $bits(pipe_exc_t);
  localparam int PIPE_CNT_W  = 32;

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Width-parametrised saturating event counter: counts enabled cycles and
// sticks at all-ones. Cleared only by the asynchronous active-low reset.
module pipe_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry valid/ready pipeline register (main + skid) with registered in_ready
// and synchronous flush. Stall/bubble counters exist only with PIPE_PERF_CNT_EN.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int EXC_W  = PIPE_EXC_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; a producer keeps valid and its payload stable until that edge.

  pipe_state_e       state_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [EXC_W-1:0]  main_exc_q,  skid_exc_q;
  logic              accept, drain;

  // Both handshake outputs decode the state register only, so neither has a
  // combinational path from the opposite side of the stage.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != SKID);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign out_data  = main_data_q;
  assign out_exc   = main_exc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_exc_q  <= '0;
      skid_data_q <= '0;
      skid_exc_q  <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_data_q <= in_data;
            main_exc_q  <= in_exc;
            state_q     <= FULL;
          end
        end
        FULL: begin
          if (accept && drain) begin
            main_data_q <= in_data;
            main_exc_q  <= in_exc;
          end else if (accept) begin
            skid_data_q <= in_data;
            skid_exc_q  <= in_exc;
            state_q     <= SKID;
          end else if (drain) begin
            state_q <= EMPTY;
          end
        end
        SKID: begin
          if (drain) begin
            main_data_q <= skid_data_q;
            main_exc_q  <= skid_exc_q;
            state_q     <= FULL;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic stall_ev, bubble_ev;

  assign stall_ev  = out_valid && !out_ready;
  assign bubble_ev = !out_valid && out_ready;

  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (stall_ev),
    .cnt_o  (stall_cnt)
  );

  pipe_sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (bubble_ev),
    .cnt_o  (bubble_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: reset, streaming, backpressure, flush,
// exception passthrough and the optional stall/bubble counters.
module tb_pipe_skid_stage;

  localparam int DATA_W = 32;
  localparam int EXC_W  = 9;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [EXC_W-1:0]  in_exc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [EXC_W-1:0]  out_exc;
  logic              flush;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  int n_cmp;
  int n_fail;

  pipe_skid_stage #(.DATA_W(DATA_W), .EXC_W(EXC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_exc     (in_exc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_exc    (out_exc),
    .flush      (flush),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    in_exc    = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    idle_inputs();
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA5;
    in_exc    = 9'h1FF;
    out_ready = 1'b1;
    flush     = 1'b0;
    step();
    step();
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++; if (out_exc !== 9'h0) begin n_fail++; $display("FAIL reset_out_exc: got %h want 0", out_exc); end
    n_cmp++; if (stall_cnt !== 4'h0 || bubble_cnt !== 4'h0) begin
      n_fail++; $display("FAIL reset_counters: got %h/%h want 0/0", stall_cnt, bubble_cnt);
    end
    rst       = 1'b1;
    in_exc    = 9'h0;
    out_ready = 1'b0;
    #0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_pre_edge_valid: got %b want 0", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hA5) begin
      n_fail++; $display("FAIL first_entry: got v=%b d=%h want v=1 d=a5", out_valid, out_data);
    end
    // Asynchronous reset in the middle of a held transfer drops the entry.
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      n_fail++; $display("FAIL async_reset_drop: got v=%b d=%h want v=0 d=0", out_valid, out_data);
    end
    step();
    rst = 1'b1;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready_%0d: got %b want 1", i, in_ready); end
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== i) begin
        n_fail++; $display("FAIL stream_out_%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, i);
      end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h10;
    step();
    in_data = 32'h11;
    step();
    n_cmp++; if (out_data !== 32'h10 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_skid_full: got d=%h rdy=%b want d=10 rdy=0", out_data, in_ready);
    end
    in_data = 32'h12;
    step();
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h10 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_hold: got v=%b d=%h rdy=%b want v=1 d=10 rdy=0", out_valid, out_data, in_ready);
    end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_data !== 32'h11 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_11: got d=%h rdy=%b want d=11 rdy=1", out_data, in_ready);
    end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h12) begin
      n_fail++; $display("FAIL bp_release_12: got v=%b d=%h want v=1 d=12", out_valid, out_data);
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_duplicate: got v=%b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h30;
    step();
    in_data = 32'h31;
    step();
    in_data = 32'h20;
    flush   = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_skid: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_no_emerge_%0d: got v=%b d=%h want v=0", i, out_valid, out_data);
      end
    end
    // A same-cycle accept while empty is discarded by flush.
    in_valid = 1'b1;
    in_data  = 32'h21;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_accept_discard: got v=%b want 0", out_valid); end
    step();
  endtask

  task automatic test_exception();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    in_exc    = 9'h040;
    step();
    in_data = 32'h56;
    in_exc  = 9'h101;
    step();
    in_valid = 1'b0;
    in_exc   = 9'h0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_data !== 32'h55 || out_exc !== 9'h040) begin
        n_fail++; $display("FAIL exc_hold_%0d: got d=%h e=%h want d=55 e=040", i, out_data, out_exc);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h56 || out_exc !== 9'h101) begin
      n_fail++; $display("FAIL exc_skid: got v=%b d=%h e=%h want v=1 d=56 e=101", out_valid, out_data, out_exc);
    end
    step();
  endtask

  task automatic test_counters();
    pulse_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h77;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
`ifdef PIPE_PERF_CNT_EN
    n_cmp++; if (stall_cnt !== 4'hF) begin n_fail++; $display("FAIL stall_saturate: got %h want f", stall_cnt); end
    n_cmp++; if (bubble_cnt !== 4'h5) begin n_fail++; $display("FAIL bubble_count: got %h want 5", bubble_cnt); end
`else
    n_cmp++; if (stall_cnt !== 4'h0) begin n_fail++; $display("FAIL stall_tied_off: got %h want 0", stall_cnt); end
    n_cmp++; if (bubble_cnt !== 4'h0) begin n_fail++; $display("FAIL bubble_tied_off: got %h want 0", bubble_cnt); end
`endif
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL counters_flush_valid: got %b want 0", out_valid); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b0;
    idle_inputs();
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_exception();
    test_counters();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
